// File: rtl/alu_operand_sequencer_pkg.sv
// Shared types and encodings for the multicycle control FSM: state
// encoding, opcode/funct constants, ALU control codes, ALU-B select codes,
// PC source codes and fault codes.
package alu_operand_sequencer_pkg;

  typedef enum logic [3:0] {
    ST_RESET    = 4'd0,
    ST_FETCH    = 4'd1,
    ST_DECODE   = 4'd2,
    ST_EXEC_R   = 4'd3,
    ST_WB_R     = 4'd4,
    ST_EXEC_I   = 4'd5,
    ST_WB_I     = 4'd6,
    ST_MEM_ADDR = 4'd7,
    ST_MEM_RD   = 4'd8,
    ST_WB_LOAD  = 4'd9,
    ST_MEM_WR   = 4'd10,
    ST_BRANCH   = 4'd11,
    ST_JUMP     = 4'd12,
    ST_FAULT    = 4'd13
  } state_t;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_J     = 6'h02;

  // R-type function codes (IR[5:0])
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_ANDN = 6'h27;

  // ALU control codes
  localparam logic [2:0] ALU_NONE = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_SUB  = 3'd2;
  localparam logic [2:0] ALU_AND  = 3'd3;
  localparam logic [2:0] ALU_OR   = 3'd4;

  // ALU-B mux select codes
  localparam logic [2:0] ALUB_REGB    = 3'd0;
  localparam logic [2:0] ALUB_FOUR    = 3'd1;
  localparam logic [2:0] ALUB_IMM     = 3'd2;
  localparam logic [2:0] ALUB_IMM_SH2 = 3'd3;
  localparam logic [2:0] ALUB_NREGB   = 3'd4;

  // PC source codes
  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  // Sticky fault codes
  localparam logic [1:0] FAULT_NONE    = 2'b00;
  localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

  // True for the R-type function codes the datapath implements
  function automatic logic rfunct_legal(input logic [5:0] fn);
    case (fn)
      FN_ADD, FN_SUB, FN_AND, FN_OR, FN_ANDN: return 1'b1;
      default:                                return 1'b0;
    endcase
  endfunction

  // State following DECODE for a given opcode/funct; illegal -> ST_FAULT
  function automatic state_t dispatch(input logic [5:0] op, input logic [5:0] fn);
    state_t nxt;
    case (op)
      OP_RTYPE:     nxt = rfunct_legal(fn) ? ST_EXEC_R : ST_FAULT;
      OP_ADDI:      nxt = ST_EXEC_I;
      OP_LW, OP_SW: nxt = ST_MEM_ADDR;
      OP_BEQ, OP_BNE: nxt = ST_BRANCH;
      OP_J:         nxt = ST_JUMP;
      default:      nxt = ST_FAULT;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/alu_operand_sequencer_mem_wait_timer.sv
// Wait-state timer: counts consecutive mem_ready-low cycles inside a memory
// wait state. 'expired' is high during the last tolerated low cycle, so the
// FSM can take the fault on that same edge unless mem_ready wins.
module alu_operand_sequencer_mem_wait_timer #(
  parameter int LIMIT = 15,
  parameter int W     = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  logic [W-1:0] count;

  // Wait counter: clear outside wait states or on completion, else count lows
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && !expired) begin
      count <= count + W'(1);
    end else begin
      count <= count;
    end
  end

  assign expired = (count == W'(LIMIT - 1));

endmodule

// File: rtl/alu_operand_sequencer.sv
// Multicycle control FSM for the CPU core. Sequences instructions through
// fetch/decode/execute/mem/writeback, drives ALU operand selects and the
// PC/IR/regfile/memory strobes, and guards memory waits with a timeout.
module alu_operand_sequencer
  import alu_operand_sequencer_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int TMR_W       = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       alu_zero,
  input  logic       mem_ready,
  output logic       alu_src_a,
  output logic [2:0] alu_src_b,
  output logic [2:0] alu_ctrl,
  output logic [1:0] pc_src,
  output logic       pc_write,
  output logic       ir_write,
  output logic       iord,
  output logic       mem_req,
  output logic       mem_we,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic [1:0] fault_code,
  output logic [3:0] state_dbg
);

  state_t state;
  state_t dec_next;
  logic   in_wait;
  logic   tmr_clear;
  logic   tmr_inc;
  logic   tmr_expired;

  assign in_wait   = (state == ST_FETCH) || (state == ST_MEM_RD) || (state == ST_MEM_WR);
  assign tmr_clear = !in_wait || mem_ready;
  assign tmr_inc   = in_wait && !mem_ready;
  assign dec_next  = dispatch(opcode, funct);
  assign state_dbg = state;

  alu_operand_sequencer_mem_wait_timer #(
    .LIMIT (MEM_TIMEOUT),
    .W     (TMR_W)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (tmr_clear),
    .inc     (tmr_inc),
    .expired (tmr_expired)
  );

  // State register and sticky fault code
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_RESET;
      fault_code <= FAULT_NONE;
    end else begin
      case (state)
        ST_RESET: state <= ST_FETCH;
        ST_FETCH: begin
          if (mem_ready) begin
            state <= ST_DECODE;
          end else if (tmr_expired) begin
            state      <= ST_FAULT;
            fault_code <= FAULT_TIMEOUT;
          end
        end
        ST_DECODE: begin
          state <= dec_next;
          if (dec_next == ST_FAULT) begin
            fault_code <= FAULT_ILLEGAL;
          end
        end
        ST_EXEC_R:   state <= ST_WB_R;
        ST_WB_R:     state <= ST_FETCH;
        ST_EXEC_I:   state <= ST_WB_I;
        ST_WB_I:     state <= ST_FETCH;
        ST_MEM_ADDR: state <= (opcode == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
        ST_MEM_RD: begin
          if (mem_ready) begin
            state <= ST_WB_LOAD;
          end else if (tmr_expired) begin
            state      <= ST_FAULT;
            fault_code <= FAULT_TIMEOUT;
          end
        end
        ST_WB_LOAD: state <= ST_FETCH;
        ST_MEM_WR: begin
          if (mem_ready) begin
            state <= ST_FETCH;
          end else if (tmr_expired) begin
            state      <= ST_FAULT;
            fault_code <= FAULT_TIMEOUT;
          end
        end
        ST_BRANCH: state <= ST_FETCH;
        ST_JUMP:   state <= ST_FETCH;
        ST_FAULT:  state <= ST_FAULT;
        default:   state <= ST_RESET;
      endcase
    end
  end

  // Moore output decode; FETCH and BRANCH strobes also qualify on inputs
  always_comb begin
    alu_src_a  = 1'b0;
    alu_src_b  = ALUB_FOUR;
    alu_ctrl   = ALU_NONE;
    pc_src     = PCSRC_ALU;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    iord       = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    case (state)
      ST_FETCH: begin
        mem_req  = 1'b1;
        alu_ctrl = ALU_ADD;
        pc_write = mem_ready;
        ir_write = mem_ready;
      end
      ST_DECODE: begin
        alu_src_b = ALUB_IMM_SH2;
        alu_ctrl  = ALU_ADD;
      end
      ST_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_src_b = ALUB_REGB;
        case (funct)
          FN_ADD:  alu_ctrl = ALU_ADD;
          FN_SUB:  alu_ctrl = ALU_SUB;
          FN_AND:  alu_ctrl = ALU_AND;
          FN_OR:   alu_ctrl = ALU_OR;
          FN_ANDN: begin
            alu_ctrl  = ALU_AND;
            alu_src_b = ALUB_NREGB;
          end
          default: alu_ctrl = ALU_ADD;
        endcase
      end
      ST_WB_R: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      ST_EXEC_I, ST_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = ALUB_IMM;
        alu_ctrl  = ALU_ADD;
      end
      ST_WB_I: reg_write = 1'b1;
      ST_MEM_RD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
      end
      ST_WB_LOAD: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      ST_MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        iord    = 1'b1;
      end
      ST_BRANCH: begin
        alu_src_a = 1'b1;
        alu_src_b = ALUB_REGB;
        alu_ctrl  = ALU_SUB;
        pc_src    = PCSRC_ALUOUT;
        if (opcode == OP_BEQ) begin
          pc_write = alu_zero;
        end else begin
          pc_write = !alu_zero;
        end
      end
      ST_JUMP: begin
        pc_src   = PCSRC_JUMP;
        pc_write = 1'b1;
      end
      default: begin
        alu_src_b = ALUB_FOUR;
      end
    endcase
  end

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Cycle-accurate scoreboard bench for alu_operand_sequencer. Each cycle the
// expected packed output vector is queued as stimulus is driven, then popped
// and compared just after the falling edge.
module tb_alu_operand_sequencer;
  import alu_operand_sequencer_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = 6'h00;
  logic [5:0] funct = 6'h00;
  logic       alu_zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       alu_src_a;
  logic [2:0] alu_src_b;
  logic [2:0] alu_ctrl;
  logic [1:0] pc_src;
  logic       pc_write, ir_write, iord, mem_req, mem_we;
  logic       reg_write, reg_dst, mem_to_reg;
  logic [1:0] fault_code;
  logic [3:0] state_dbg;

  int n_tests = 0;
  int n_fail  = 0;
  logic [22:0] exp_q[$];
  logic [22:0] got;

  alu_operand_sequencer dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
    .alu_zero(alu_zero), .mem_ready(mem_ready),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl),
    .pc_src(pc_src), .pc_write(pc_write), .ir_write(ir_write), .iord(iord),
    .mem_req(mem_req), .mem_we(mem_we), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .fault_code(fault_code),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // strobe order: {pc_write, ir_write, iord, mem_req, mem_we, reg_write, reg_dst, mem_to_reg}
  assign got = {state_dbg, alu_src_a, alu_src_b, alu_ctrl, pc_src,
                pc_write, ir_write, iord, mem_req, mem_we, reg_write, reg_dst, mem_to_reg,
                fault_code};

  function automatic logic [22:0] mk(input logic [3:0] st, input logic a,
                                     input logic [2:0] b, input logic [2:0] c,
                                     input logic [1:0] ps, input logic [7:0] stb,
                                     input logic [1:0] f);
    return {st, a, b, c, ps, stb, f};
  endfunction

  function automatic logic [22:0] dflt(input logic [3:0] st, input logic [1:0] f);
    return mk(st, 1'b0, 3'd1, 3'd0, 2'd0, 8'b0000_0000, f);
  endfunction

  task automatic check(input string tag, input logic [22:0] g, input logic [22:0] e);
    n_tests++;
    if (g !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, g, e);
    end
  endtask

  // Drive one cycle of inputs, queue its expectation, then compare
  task automatic cyc(input string tag, input logic mr, input logic az, input logic [22:0] e);
    @(negedge clk);
    mem_ready = mr;
    alu_zero  = az;
    exp_q.push_back(e);
    #1;
    check(tag, got, exp_q.pop_front());
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b1;
    mem_ready = 1'b0;
    exp_q.push_back(dflt(4'(ST_RESET), 2'b00));
    #1;
    check("reset", got, exp_q.pop_front());
    @(negedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic fetch_decode(input string tag);
    cyc({tag, "_fetch"}, 1'b1, 1'b0, mk(4'(ST_FETCH), 1'b0, 3'd1, 3'd1, 2'd0, 8'b1101_0000, 2'b00));
    cyc({tag, "_decode"}, 1'b1, 1'b0, mk(4'(ST_DECODE), 1'b0, 3'd3, 3'd1, 2'd0, 8'b0000_0000, 2'b00));
  endtask

  logic [5:0] fn_tab[5]  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27};
  logic [2:0] ctl_tab[5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd3};
  logic [2:0] b_tab[5]   = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd4};

  initial begin
    do_reset();

    // R-type: FETCH, DECODE, EXEC_R, WB_R
    for (int i = 0; i < 5; i++) begin
      opcode = 6'h00;
      funct  = fn_tab[i];
      fetch_decode("rtype");
      cyc("rtype_exec", 1'b1, 1'b0, mk(4'(ST_EXEC_R), 1'b1, b_tab[i], ctl_tab[i], 2'd0, 8'b0000_0000, 2'b00));
      cyc("rtype_wb", 1'b1, 1'b0, mk(4'(ST_WB_R), 1'b0, 3'd1, 3'd0, 2'd0, 8'b0000_0110, 2'b00));
    end

    // addi
    opcode = 6'h08;
    fetch_decode("addi");
    cyc("addi_exec", 1'b1, 1'b0, mk(4'(ST_EXEC_I), 1'b1, 3'd2, 3'd1, 2'd0, 8'b0000_0000, 2'b00));
    cyc("addi_wb", 1'b1, 1'b0, mk(4'(ST_WB_I), 1'b0, 3'd1, 3'd0, 2'd0, 8'b0000_0100, 2'b00));

    // lw with three wait states in MEM_RD
    opcode = 6'h23;
    fetch_decode("lw");
    cyc("lw_addr", 1'b1, 1'b0, mk(4'(ST_MEM_ADDR), 1'b1, 3'd2, 3'd1, 2'd0, 8'b0000_0000, 2'b00));
    for (int i = 0; i < 3; i++) begin
      cyc("lw_wait", 1'b0, 1'b0, mk(4'(ST_MEM_RD), 1'b0, 3'd1, 3'd0, 2'd0, 8'b0011_0000, 2'b00));
    end
    cyc("lw_rd", 1'b1, 1'b0, mk(4'(ST_MEM_RD), 1'b0, 3'd1, 3'd0, 2'd0, 8'b0011_0000, 2'b00));
    cyc("lw_wb", 1'b1, 1'b0, mk(4'(ST_WB_LOAD), 1'b0, 3'd1, 3'd0, 2'd0, 8'b0000_0101, 2'b00));

    // sw
    opcode = 6'h2B;
    fetch_decode("sw");
    cyc("sw_addr", 1'b1, 1'b0, mk(4'(ST_MEM_ADDR), 1'b1, 3'd2, 3'd1, 2'd0, 8'b0000_0000, 2'b00));
    cyc("sw_wr", 1'b1, 1'b0, mk(4'(ST_MEM_WR), 1'b0, 3'd1, 3'd0, 2'd0, 8'b0011_1000, 2'b00));

    // beq/bne with both zero-flag values
    for (int i = 0; i < 4; i++) begin
      logic is_bne;
      logic az;
      logic take;
      is_bne = (i >= 2);
      az     = i[0];
      take   = is_bne ? !az : az;
      opcode = is_bne ? 6'h05 : 6'h04;
      fetch_decode("branch");
      cyc("branch_exec", 1'b1, az,
          mk(4'(ST_BRANCH), 1'b1, 3'd0, 3'd2, 2'd1, {take, 7'b000_0000}, 2'b00));
    end

    // jump
    opcode = 6'h02;
    fetch_decode("jump");
    cyc("jump_exec", 1'b1, 1'b0, mk(4'(ST_JUMP), 1'b0, 3'd1, 3'd0, 2'd2, 8'b1000_0000, 2'b00));

    // 14 low cycles, ready on the 15th: no fault
    for (int i = 0; i < 14; i++) begin
      cyc("nearto_wait", 1'b0, 1'b0, mk(4'(ST_FETCH), 1'b0, 3'd1, 3'd1, 2'd0, 8'b0001_0000, 2'b00));
    end
    cyc("nearto_fetch", 1'b1, 1'b0, mk(4'(ST_FETCH), 1'b0, 3'd1, 3'd1, 2'd0, 8'b1101_0000, 2'b00));
    cyc("nearto_decode", 1'b1, 1'b0, mk(4'(ST_DECODE), 1'b0, 3'd3, 3'd1, 2'd0, 8'b0000_0000, 2'b00));
    cyc("nearto_jump", 1'b1, 1'b0, mk(4'(ST_JUMP), 1'b0, 3'd1, 3'd0, 2'd2, 8'b1000_0000, 2'b00));

    // 15 low cycles in FETCH: timeout fault, sticky and not exited
    for (int i = 0; i < 15; i++) begin
      cyc("to_wait", 1'b0, 1'b0, mk(4'(ST_FETCH), 1'b0, 3'd1, 3'd1, 2'd0, 8'b0001_0000, 2'b00));
    end
    for (int i = 0; i < 3; i++) begin
      cyc("to_fault", 1'b1, 1'b0, dflt(4'(ST_FAULT), 2'b10));
    end
    do_reset();

    // illegal opcode
    opcode = 6'h3F;
    fetch_decode("illop");
    cyc("illop_fault", 1'b1, 1'b0, dflt(4'(ST_FAULT), 2'b01));
    cyc("illop_hold", 1'b1, 1'b0, dflt(4'(ST_FAULT), 2'b01));
    do_reset();

    // R-type with unsupported funct
    opcode = 6'h00;
    funct  = 6'h21;
    fetch_decode("illfn");
    cyc("illfn_fault", 1'b1, 1'b0, dflt(4'(ST_FAULT), 2'b01));
    do_reset();

    // asynchronous reset while waiting in MEM_WR
    opcode = 6'h2B;
    fetch_decode("swrst");
    cyc("swrst_addr", 1'b1, 1'b0, mk(4'(ST_MEM_ADDR), 1'b1, 3'd2, 3'd1, 2'd0, 8'b0000_0000, 2'b00));
    cyc("swrst_wr", 1'b0, 1'b0, mk(4'(ST_MEM_WR), 1'b0, 3'd1, 3'd0, 2'd0, 8'b0011_1000, 2'b00));
    #2;
    reset = 1'b1;
    exp_q.push_back(dflt(4'(ST_RESET), 2'b00));
    #1;
    check("async_rst", got, exp_q.pop_front());
    @(negedge clk);
    #1;
    reset = 1'b0;
    opcode = 6'h00;
    funct  = 6'h20;
    fetch_decode("after_rst");
    cyc("after_rst_exec", 1'b1, 1'b0, mk(4'(ST_EXEC_R), 1'b1, 3'd0, 3'd1, 2'd0, 8'b0000_0000, 2'b00));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
